// File: rtl/tv_pkg.sv
// tv_pkg: shared state encoding, default widths and vector layout for the
// test-vector runner.
package tv_pkg;
    localparam int IN_W_DEF  = 3;
    localparam int OUT_W_DEF = 1;
    localparam int DEPTH_DEF = 16;
    localparam int ERR_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [IN_W_DEF-1:0]  in;
        logic [OUT_W_DEF-1:0] exp;
    } vector_t;
endpackage

// File: rtl/tv_ram.sv
// tv_ram: vector store with synchronous write and asynchronous read.
module tv_ram import tv_pkg::*; #(
    parameter int DW    = IN_W_DEF + OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];
endmodule

// File: rtl/tv_runner.sv
// tv_runner: drives stored vectors into a combinational DUT one per cycle,
// compares its response and records mismatch statistics.
module tv_runner import tv_pkg::*; #(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ERR_W = ERR_W_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [IN_W+OUT_W-1:0] wr_data,
    input  logic [AW:0]           num_vec,
    input  logic                  start,
    input  logic                  hold,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [ERR_W-1:0]      errors,
    output logic [AW-1:0]         first_err_idx,
    output logic                  err_seen,
    output logic [AW-1:0]         vec_idx
);
    localparam int VW = IN_W + OUT_W;
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [OUT_W-1:0] exp_q, exp_d;
    logic [AW:0]      n_q, n_d;
    logic [AW-1:0]    vec_idx_q, vec_idx_d;
    logic [ERR_W-1:0] errors_q, errors_d;
    logic [AW-1:0]    first_q, first_d;
    logic             err_seen_q, err_seen_d;
    logic             mismatch_q, mismatch_d;

    logic [AW-1:0] rd_addr;
    logic [VW-1:0] rd_data;
    logic [AW:0]   n_clamp;
    logic          last;

    // In RUN the read port looks one vector ahead; otherwise it presents entry 0 for a start.
    assign rd_addr = (state_q == RUN) ? vec_idx_q + AW'(1) : '0;
    assign n_clamp = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
    assign last    = {1'b0, vec_idx_q} == n_q - (AW+1)'(1);

    tv_ram #(.DW(VW), .DEPTH(DEPTH)) u_ram (
        .clk (clk),
        .we  (wr_en && state_q != RUN),
        .wa  (wr_addr),
        .wd  (wr_data),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        dut_in_d   = dut_in_q;
        exp_d      = exp_q;
        n_d        = n_q;
        vec_idx_d  = vec_idx_q;
        errors_d   = errors_q;
        first_d    = first_q;
        err_seen_d = err_seen_q;
        mismatch_d = 1'b0;
        if (state_q == RUN) begin
            if (!hold) begin
                if (dut_out != exp_q) begin
                    mismatch_d = 1'b1;
                    errors_d   = &errors_q ? errors_q : errors_q + ERR_W'(1);
                    if (!err_seen_q) begin
                        first_d    = vec_idx_q;
                        err_seen_d = 1'b1;
                    end
                end
                if (last) begin
                    state_d = DONE;
                end else begin
                    vec_idx_d = vec_idx_q + AW'(1);
                    dut_in_d  = rd_data[VW-1:OUT_W];
                    exp_d     = rd_data[OUT_W-1:0];
                end
            end
        end else if (start) begin
            errors_d   = '0;
            err_seen_d = 1'b0;
            first_d    = '0;
            n_d        = n_clamp;
            if (n_clamp == '0) begin
                state_d = DONE;
            end else begin
                dut_in_d  = rd_data[VW-1:OUT_W];
                exp_d     = rd_data[OUT_W-1:0];
                vec_idx_d = '0;
                state_d   = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dut_in_q   <= '0;
            exp_q      <= '0;
            n_q        <= '0;
            vec_idx_q  <= '0;
            errors_q   <= '0;
            first_q    <= '0;
            err_seen_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dut_in_q   <= dut_in_d;
            exp_q      <= exp_d;
            n_q        <= n_d;
            vec_idx_q  <= vec_idx_d;
            errors_q   <= errors_d;
            first_q    <= first_d;
            err_seen_q <= err_seen_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign dut_in        = dut_in_q;
    assign busy          = state_q == RUN;
    assign done          = state_q == DONE;
    assign mismatch      = mismatch_q;
    assign errors        = errors_q;
    assign first_err_idx = first_q;
    assign err_seen      = err_seen_q;
    assign vec_idx       = vec_idx_q;
endmodule

// File: tb/tb_tv_runner.sv
// tb_tv_runner: directed checks of the vector runner against y = ~b&~c | a&~b.
module tb_tv_runner;
    import tv_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, hold = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic [4:0]  num_vec = '0;
    logic [2:0]  dut_in, s_dut_in;
    logic        dut_out, s_dut_out;
    logic        busy, done, mismatch, err_seen;
    logic        s_busy, s_done, s_mismatch, s_err_seen;
    logic [15:0] errors;
    logic [1:0]  s_errors;
    logic [3:0]  first_err_idx, vec_idx, s_first, s_vec_idx;
    int          n_cmp = 0, n_bad = 0;

    function automatic logic f(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    assign dut_out   = f(dut_in);
    assign s_dut_out = f(s_dut_in);

    always #5 clk = ~clk;

    tv_runner u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start), .hold(hold), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .mismatch(mismatch), .errors(errors),
        .first_err_idx(first_err_idx), .err_seen(err_seen), .vec_idx(vec_idx)
    );

    tv_runner #(.ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start), .hold(hold), .dut_in(s_dut_in), .dut_out(s_dut_out),
        .busy(s_busy), .done(s_done), .mismatch(s_mismatch), .errors(s_errors),
        .first_err_idx(s_first), .err_seen(s_err_seen), .vec_idx(s_vec_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic wr(input int a, input logic [2:0] vin, input logic e);
        vector_t v;
        v.in  = vin;
        v.exp = e;
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick(input int n);
        start   = 1'b1;
        num_vec = 5'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        int cnt, stable;
        logic [8:0] mm;
        repeat (2) @(negedge clk);
        check("rst_dut_in", dut_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_errors", errors, 0);
        check("rst_vec_idx", vec_idx, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, 3'(i), f(3'(i)));

        kick(8);
        check("pass_busy", busy, 1);
        check("pass_dut_in0", dut_in, 0);
        mm = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            mm[k] = mismatch;
            if (k == 7) check("pass_not_early", done, 0);
        end
        check("pass_done", done, 1);
        check("pass_busy_low", busy, 0);
        check("pass_errors", errors, 0);
        check("pass_err_seen", err_seen, 0);
        check("pass_mm_never", mm, 0);
        check("pass_vec_idx", vec_idx, 7);
        check("pass_dut_in_hold", dut_in, 7);

        wr(2, 3'd2, ~f(3'd2));
        wr(5, 3'd5, ~f(3'd5));
        kick(8);
        mm = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            mm[k] = mismatch;
        end
        check("fault_mm_edges", mm, 9'h048);
        check("fault_errors", errors, 2);
        check("fault_first", first_err_idx, 2);
        check("fault_err_seen", err_seen, 1);
        check("fault_done", done, 1);
        @(negedge clk);
        check("fault_mm_low", mismatch, 0);

        kick(8);
        cnt = 0;
        stable = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt >= 4 && cnt <= 7 && dut_in == 3'd4) stable++;
            if (cnt == 4) hold = 1'b1;
            if (cnt == 6) check("hold_busy", busy, 1);
            if (cnt == 6) check("hold_mm", mismatch, 0);
            if (cnt == 7) hold = 1'b0;
            if (cnt == 8) check("hold_resume", dut_in, 5);
        end
        check("hold_stable", stable, 4);
        check("hold_latency", cnt, 11);
        check("hold_errors", errors, 2);
        check("hold_first", first_err_idx, 2);

        kick(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_errors", errors, 0);
        check("zero_err_seen", err_seen, 0);
        check("zero_dut_in", dut_in, 7);

        wr(2, 3'd2, f(3'd2));
        wr(5, 3'd5, f(3'd5));
        kick(16);
        wait_done(cnt);
        check("full_latency", cnt, 16);
        check("full_vec_idx", vec_idx, 15);
        check("full_dut_in", dut_in, 7);
        check("full_errors", errors, 0);

        kick(8);
        cnt = 0;
        while (!done && cnt < 100) begin
            if (cnt == 1) begin
                wr_en   = 1'b1;
                wr_addr = 4'd1;
                wr_data = {3'd1, ~f(3'd1)};
            end
            if (cnt == 2) begin
                wr_en   = 1'b0;
                start   = 1'b1;
                num_vec = 5'd4;
            end
            if (cnt == 3) start = 1'b0;
            @(negedge clk);
            cnt++;
            if (cnt == 3) check("ign_start_idx", vec_idx, 3);
        end
        check("ign_start_len", cnt, 8);
        check("wp_errors_run", errors, 0);
        kick(8);
        wait_done(cnt);
        check("wp_errors_rerun", errors, 0);
        check("wp_err_seen", err_seen, 0);

        for (int i = 0; i < 6; i++) wr(i, 3'(i), ~f(3'(i)));
        kick(6);
        repeat (3) @(negedge clk);
        check("pre_rst_idx", vec_idx, 3);
        check("pre_rst_errors", errors, 3);
        #2 reset = 1'b1;
        #1;
        check("arst_dut_in", dut_in, 0);
        check("arst_vec_idx", vec_idx, 0);
        check("arst_errors", errors, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err_seen", err_seen, 0);
        check("arst_first", first_err_idx, 0);
        check("arst_mismatch", mismatch, 0);
        @(negedge clk);
        reset = 1'b0;
        kick(6);
        wait_done(cnt);
        check("fail_latency", cnt, 6);
        check("fail_errors", errors, 6);
        check("fail_first", first_err_idx, 0);
        check("sat_errors", s_errors, 3);
        check("sat_err_seen", s_err_seen, 1);
        check("sat_done", s_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
